// File: rtl/btn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_pkg : shared button indices, default 100 MHz timing, repeat FSM states
// Revision: 1.0
// ----------------------------------------------------------------------------
package btn_pkg;

  localparam int BTN_LEFT    = 0;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_DROP    = 2;
  localparam int BTN_POP     = 3;
  localparam int BTN_RESTART = 4;
  localparam int N_BTN       = 5;

  // 10 ms debounce, 500 ms first repeat, 150 ms repeat period at 100 MHz
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_RATE   = 15000000;
  localparam int DEF_RPT_W         = 26;

  localparam logic [1:0] RPT_IDLE  = 2'd0;
  localparam logic [1:0] RPT_DELAY = 2'd1;
  localparam logic [1:0] RPT_RATE  = 2'd2;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce_ch : one button channel - 2-flop sync, stable-count filter,
//                   optional hold-to-repeat FSM
// Revision: 1.0
// ----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int RPT_W         = DEF_RPT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic btn_repeat_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             repeat_q;
  logic             repeat_d;
  logic             w_accept;
  logic             w_acc_press;
  logic             w_acc_release;
  logic             w_rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
    end
  end

  // Any sample agreeing with the current level restarts the stability count
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    w_accept = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d  = sync_q;
      cnt_d    = '0;
      w_accept = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign w_acc_press   = w_accept & sync_q;
  assign w_acc_release = w_accept & ~sync_q;

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

      logic [1:0]       state_q;
      logic [1:0]       state_d;
      logic [RPT_W-1:0] rcnt_q;
      logic [RPT_W-1:0] rcnt_d;
      logic             w_fire;

      // Release wins over a coinciding terminal count so no repeat leaks out
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        w_fire  = 1'b0;
        if (w_acc_release) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              if (w_acc_press) begin
                state_d = RPT_DELAY;
                rcnt_d  = '0;
              end
            end
            RPT_DELAY: begin
              if (rcnt_q == DELAY_LAST) begin
                w_fire  = 1'b1;
                state_d = RPT_RATE;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + RPT_W'(1);
              end
            end
            RPT_RATE: begin
              if (rcnt_q == RATE_LAST) begin
                w_fire = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + RPT_W'(1);
              end
            end
            default: begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      assign w_rpt_fire = w_fire;
    end else begin : g_no_repeat
      assign w_rpt_fire = 1'b0;
    end
  endgenerate

  assign press_d   = w_acc_press | w_rpt_fire;
  assign release_d = w_acc_release;
  assign repeat_d  = w_rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign btn_repeat_o  = repeat_q;

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_debounce_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce_multi : N independent debounced button channels with
//                      press/release pulses and optional auto-repeat
// Revision: 1.0
// ----------------------------------------------------------------------------
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_CH          = N_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int RPT_W         = DEF_RPT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw_i,
  output logic [N_CH-1:0] btn_level_o,
  output logic [N_CH-1:0] btn_press_o,
  output logic [N_CH-1:0] btn_release_o,
  output logic [N_CH-1:0] btn_repeat_o
);

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE),
        .RPT_W         (RPT_W)
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .btn_raw_i     (btn_raw_i[g]),
        .btn_level_o   (btn_level_o[g]),
        .btn_press_o   (btn_press_o[g]),
        .btn_release_o (btn_release_o[g]),
        .btn_repeat_o  (btn_repeat_o[g])
      );
    end
  endgenerate

endmodule : btn_debounce_multi
`default_nettype wire

// File: tb/tb_btn_debounce_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_btn_debounce_multi : two DUTs (repeat off / on) on shared raw inputs,
//                         checked every cycle against a sample-window model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_btn_debounce_multi;

  localparam int N  = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] lvl0, prs0, rel0, rep0;
  logic [N-1:0] lvl1, prs1, rel1, rep1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .N_CH(N), .STABLE_CYCLES(SC), .CNT_W(3), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(4)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_raw_i(raw),
    .btn_level_o(lvl0), .btn_press_o(prs0),
    .btn_release_o(rel0), .btn_repeat_o(rep0)
  );

  btn_debounce_multi #(
    .N_CH(N), .STABLE_CYCLES(SC), .CNT_W(3), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_raw_i(raw),
    .btn_level_o(lvl1), .btn_press_o(prs1),
    .btn_release_o(rel1), .btn_repeat_o(rep1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: hist[c][i] is the raw value sampled i+1 edges ago; the level flips
  // once the last SC synchronised samples (2..5 edges old) all oppose it.
  logic [SC:0]  hist [N];
  int           age  [N];
  logic [N-1:0] m_lvl, m_prs, m_rel, m_rep;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lvl = '0; m_prs = '0; m_rel = '0; m_rep = '0;
      for (int c = 0; c < N; c++) begin
        hist[c] = '0;
        age[c]  = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        m_prs[c] = 1'b0; m_rel[c] = 1'b0; m_rep[c] = 1'b0;
        if (hist[c][SC:1] == {SC{~m_lvl[c]}}) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            m_prs[c] = 1'b1;
            age[c]   = 0;
          end else begin
            m_rel[c] = 1'b1;
          end
        end else if (m_lvl[c]) begin
          age[c]++;
          if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RR == 0)) m_rep[c] = 1'b1;
        end
        hist[c] = {hist[c][SC-1:0], raw[c]};
      end
    end
  end

  always @(negedge clk) begin
    check("lvl0", lvl0, m_lvl);
    check("prs0", prs0, m_prs);
    check("rel0", rel0, m_rel);
    check("rep0", rep0, '0);
    check("lvl1", lvl1, m_lvl);
    check("prs1", prs1, m_prs | m_rep);
    check("rel1", rel1, m_rel);
    check("rep1", rep1, m_rep);
  end

  logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int   npress;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_lvl", {lvl1, lvl0}, 4'b0000);
    check("rst_prs", {prs1, prs0}, 4'b0000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // clean press on ch0 and repeat train on dut1
    raw = 2'b01;
    repeat (5) @(negedge clk);
    check("t1_pre_lvl", lvl0, 2'b00);
    check("t1_pre_prs", prs0, 2'b00);
    @(negedge clk);
    check("t1_lvl", lvl0, 2'b01);
    check("t1_prs", prs0, 2'b01);
    check("t1_rel", rel0, 2'b00);
    @(negedge clk);
    check("t1_pulse_end", prs0, 2'b00);
    repeat (8) @(negedge clk);
    check("t1_rep_p9", rep1, 2'b00);
    @(negedge clk);
    check("t1_rep_p10", rep1, 2'b01);
    check("t1_prs_p10", prs1, 2'b01);
    check("t1_prs0_p10", prs0, 2'b00);
    repeat (3) @(negedge clk);
    check("t1_rep_p13", rep1, 2'b01);
    repeat (17) @(negedge clk);

    // glitch rejection then release
    raw = 2'b00;
    @(negedge clk);
    raw = 2'b01;
    repeat (10) @(negedge clk);
    check("t3_glitch_lvl", lvl0, 2'b01);
    raw = 2'b00;
    repeat (5) @(negedge clk);
    check("t3_pre_rel", rel0, 2'b00);
    @(negedge clk);
    check("t3_rel", rel0, 2'b01);
    check("t3_lvl", lvl0, 2'b00);
    check("t3_rel_norep", rep1, 2'b00);
    repeat (8) @(negedge clk);

    // bounce: last 0->1 at step 5, press expected at step 11 only
    npress = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 11) check("t4_press", prs0, 2'b01);
      if (prs0[0]) npress++;
      raw[0] = (c < 9) ? pat[c] : 1'b1;
    end
    check("t4_npress", npress, 1);
    raw = 2'b00;
    repeat (10) @(negedge clk);

    // reset during the DELAY count with button held
    raw = 2'b01;
    repeat (6) @(negedge clk);
    check("t5_prs", prs1, 2'b01);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_lvl", {lvl1, lvl0}, 4'b0000);
    check("t5_rst_pulses", {prs1, rep1, rel1}, 6'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_pre_prs", prs1, 2'b00);
    @(negedge clk);
    check("t5_post_prs", prs1, 2'b01);
    check("t5_post_rep", rep1, 2'b00);
    check("t5_post_lvl", lvl1, 2'b01);
    repeat (14) @(negedge clk);
    raw = 2'b00;
    repeat (10) @(negedge clk);

    // simultaneous channels
    raw = 2'b11;
    repeat (6) @(negedge clk);
    check("t6_prs0", prs0, 2'b11);
    check("t6_prs1", prs1, 2'b11);
    repeat (3) @(negedge clk);
    raw = 2'b00;
    repeat (6) @(negedge clk);
    check("t6_rel", rel0, 2'b11);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_btn_debounce_multi
`default_nettype wire

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised N-channel push-button conditioner for the board's game-control buttons (column left/right, drop, pop, restart). Each channel synchronises a raw asynchronous button input, applies a stable-count debounce filter, and emits a debounced level, single-cycle press/release pulses and an optional hold-to-repeat press stream. It sits between the board I/O pins and the game-control FSM, which consumes only the single-cycle pulses.

Parameters:
N_CH, 5, number of independent button channels
STABLE_CYCLES, 1000000, consecutive cycles of a changed synchronised input needed to accept a new level (10 ms at 100 MHz); must be >= 2
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > STABLE_CYCLES
REPEAT_EN, 0, 1 enables auto-repeat press pulses while a button is held
REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first repeat pulse; must be >= 1
REPEAT_RATE, 15000000, cycles between subsequent repeat pulses; must be >= 1
RPT_W, 26, repeat counter width; must satisfy 2**RPT_W > max(REPEAT_DELAY, REPEAT_RATE)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous and active-high
btn_raw  input  N_CH  raw button pins, asynchronous, 1 = pressed
btn_level  output  N_CH  debounced level per channel
btn_press  output  N_CH  1-cycle pulse on accepted press, plus repeat pulses when REPEAT_EN=1
btn_release  output  N_CH  1-cycle pulse on accepted release
btn_repeat  output  N_CH  1-cycle pulse on repeat events only (always 0 when REPEAT_EN=0)

Behaviour:
- Reset (async assert, immediate effect): sync flops, counters, btn_level, btn_press, btn_release and btn_repeat all clear to 0. Reset takes effect mid-count or mid-repeat with no residual pulse after release.
- Synchroniser: 2-flop chain per channel; sync_q is the second flop output. Raw-to-sync_q latency is 2 cycles.
- Filter, per channel, every cycle:
  - sync_q == btn_level: cnt <= 0.
  - sync_q != btn_level and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - sync_q != btn_level and cnt == STABLE_CYCLES-1: btn_level <= sync_q and cnt <= 0. Raise btn_press (0->1) or btn_release (1->0) for exactly that cycle, registered, aligned with the btn_level change.
- A single agreeing sample (glitch back to btn_level) restarts the count from 0. Bounces shorter than STABLE_CYCLES never reach outputs.
- Press latency from a clean raw step is 2 + STABLE_CYCLES cycles until btn_level and btn_press assert.
- Button held through reset deassertion: treated as a fresh press. btn_press fires 2 + STABLE_CYCLES cycles after rst falls.
- Repeat (REPEAT_EN=1), per channel:
  - States IDLE, DELAY, RATE.
  - IDLE->DELAY on the accepted press, with rcnt <= 0.
  - In DELAY, when rcnt == REPEAT_DELAY-1: pulse btn_repeat and btn_press together, go to RATE, rcnt <= 0.
  - In RATE, when rcnt == REPEAT_RATE-1: pulse both, rcnt <= 0.
  - Otherwise rcnt increments.
  - Any state returns to IDLE on the accepted release, and no repeat pulse fires in the release cycle.
  - Repeat logic is absent or constant-0 when REPEAT_EN=0.
- btn_press and btn_release are never high in the same cycle for a channel. Channels are fully independent; simultaneous events on several channels pulse simultaneously.
- Counters never wrap: cnt saturates by construction at STABLE_CYCLES-1, and rcnt resets at its terminal value.

Decomposition:
- Shared package btn_pkg: button index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_DROP=2, BTN_POP=3, BTN_RESTART=4), N_BTN=5, and default timing constants for a 100 MHz clock.
- Sub-module btn_debounce_ch: one channel containing synchroniser, filter and repeat FSM, with the same parameters minus N_CH. The top level is a generate loop over N_CH instances.

Test Plan:
Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_CH=2, unless stated otherwise.
- Clean press: ch0 raw 0->1 at cycle 0 and held -> btn_level[0]=1 and btn_press[0]=1 at cycle 6 only. btn_release stays 0; ch1 unchanged.
- Bounce rejection: raw pattern 1,0,1,1,0,1,1,1,1 -> no pulse until 4 consecutive synced 1s. Exactly one btn_press, 6 cycles after the final 0->1.
- Release plus glitch: held button, raw 1-cycle 0 glitch -> no release. Then raw 0 held -> btn_release=1 for one cycle 6 cycles later, and btn_level returns to 0.
- Repeat, REPEAT_EN=1, held 30 cycles after press at cycle P -> btn_press at P, P+10, P+13, P+16, ... and btn_repeat only at P+10 onwards. Release stops repeats, with no repeat in the release cycle.
- Reset mid-operation: assert rst during DELAY count, with button held -> all outputs 0 immediately. After deassert, btn_press fires 2+4 cycles later with no stale repeat pulse.
- Simultaneous channels: both raw 0->1 at the same cycle -> btn_press=2'b11 in the same cycle, with identical timing.
